// File: rtl/relu_grad_pkg.sv
// Shared CNN package: default data width and mask-buffer depth used by the
// forward ReLU and relu_grad, plus the ReLU pass-through rule as a helper.
package relu_grad_pkg;

  localparam int unsigned CnnDW    = 8;
  localparam int unsigned CnnDepth = 16;

  // Forward ReLU passes a value when its sign bit is clear (x >= 0).
  function automatic logic relu_mask_bit(input logic sign);
    return ~sign;
  endfunction

endpackage

// File: rtl/relu_grad_if.sv
// Bus interface for relu_grad.
//   master: drives clr, fwd_en, fwd_A, bwd_en, dY; observes results.
//   slave : receives strobes/data; drives dA, bwd_valid, count, full, empty,
//           ovf, udf.
interface relu_grad_if import relu_grad_pkg::*; #(
  parameter int unsigned D_W   = CnnDW,
  parameter int unsigned DEPTH = CnnDepth
) ();

  logic                        clr;
  logic                        fwd_en;
  logic signed [D_W-1:0]       fwd_A;
  logic                        bwd_en;
  logic signed [D_W-1:0]       dY;
  logic signed [D_W-1:0]       dA;
  logic                        bwd_valid;
  logic [$clog2(DEPTH):0]      count;
  logic                        full;
  logic                        empty;
  logic                        ovf;
  logic                        udf;

  modport master (
    output clr, fwd_en, fwd_A, bwd_en, dY,
    input  dA, bwd_valid, count, full, empty, ovf, udf
  );

  modport slave (
    input  clr, fwd_en, fwd_A, bwd_en, dY,
    output dA, bwd_valid, count, full, empty, ovf, udf
  );

endinterface

// File: rtl/relu_mask_fifo.sv
// 1-bit-wide FIFO holding ReLU mask bits between forward and backward passes.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_clr        synchronous flush (pointers and count)
//   i_wr_en      write i_wr_bit (caller guarantees acceptance)
//   i_rd_en      pop oldest bit (caller guarantees acceptance)
//   o_rd_bit     oldest stored bit (combinational)
//   o_count      stored bit count; o_full / o_empty decoded from it
module relu_mask_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_wr_en,
  input  logic                    i_wr_bit,
  input  logic                    i_rd_en,
  output logic                    o_rd_bit,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_wr_en, i_rd_en})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; stale bits are unreachable once count is zero.
  always_ff @(posedge clk) begin
    if (i_wr_en && !i_clr) r_mem[r_wr_ptr] <= i_wr_bit;
  end

  assign o_rd_bit = r_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/relu_grad.sv
// ReLU backward pass: records a mask bit per forward sample and gates each
// upstream gradient with the oldest mask, in FIFO order.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       relu_grad_if slave: clr, fwd_en/fwd_A, bwd_en/dY in;
//             dA/bwd_valid (registered), count/full/empty, sticky ovf/udf out
module relu_grad import relu_grad_pkg::*; #(
  parameter int unsigned D_W   = CnnDW,
  parameter int unsigned DEPTH = CnnDepth
) (
  input  logic        clk,
  input  logic        rst,
  relu_grad_if.slave  bus
);

  logic                   w_rd_acc;
  logic                   w_wr_acc;
  logic                   w_rd_bit;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;

  logic signed [D_W-1:0]  r_da;
  logic                   r_bwd_valid;
  logic                   r_ovf;
  logic                   r_udf;

  // A read frees a slot in the same cycle, so a write into a full buffer
  // proceeds when a read is also accepted. clr masks both strobes.
  assign w_rd_acc = bus.bwd_en & ~w_empty & ~bus.clr;
  assign w_wr_acc = bus.fwd_en & ~bus.clr & (~w_full | w_rd_acc);

  relu_mask_fifo #(
    .DEPTH (DEPTH)
  ) u_mask_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (bus.clr),
    .i_wr_en  (w_wr_acc),
    .i_wr_bit (relu_mask_bit(bus.fwd_A[D_W-1])),
    .i_rd_en  (w_rd_acc),
    .o_rd_bit (w_rd_bit),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_da        <= '0;
      r_bwd_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else if (bus.clr) begin
      r_bwd_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_bwd_valid <= w_rd_acc;
      if (w_rd_acc) r_da <= w_rd_bit ? bus.dY : '0;
      if (bus.fwd_en && w_full && !w_rd_acc) r_ovf <= 1'b1;
      if (bus.bwd_en && w_empty) r_udf <= 1'b1;
    end
  end

  assign bus.dA        = r_da;
  assign bus.bwd_valid = r_bwd_valid;
  assign bus.count     = w_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.ovf       = r_ovf;
  assign bus.udf       = r_udf;

endmodule

// File: tb/tb_relu_grad.sv
module tb_relu_grad;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic rst;

  relu_grad_if #(.D_W(DW), .DEPTH(DEPTH)) bus ();

  relu_grad #(.D_W(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of mask bits plus flags.
  bit                   mq[$];
  logic signed [DW-1:0] sb[$];
  bit                   m_ovf, m_udf, m_valid;
  logic signed [DW-1:0] m_da;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_ovf = 0; m_udf = 0; m_valid = 0; m_da = '0;
  endtask

  task automatic model_step(input bit c, input bit fe, input logic signed [DW-1:0] fa,
                            input bit be, input logic signed [DW-1:0] dy);
    int n = mq.size();
    bit rd, wr, m;
    if (c) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_valid = 0;
    end else begin
      rd = be && (n > 0);
      wr = fe && ((n < DEPTH) || rd);
      if (be && n == 0) m_udf = 1;
      if (fe && n == DEPTH && !rd) m_ovf = 1;
      m_valid = rd;
      if (rd) begin
        m = mq.pop_front();
        m_da = m ? dy : '0;
        sb.push_back(m_da);
      end
      if (wr) mq.push_back(fa >= 0);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(bus.count), mq.size());
    chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    chk("udf", 32'(bus.udf), 32'(m_udf));
    chk("bwd_valid", 32'(bus.bwd_valid), 32'(m_valid));
    chk("dA_hold", bus.dA, m_da);
  endtask

  task automatic step(input bit c, input bit fe, input logic signed [DW-1:0] fa,
                      input bit be, input logic signed [DW-1:0] dy);
    @(negedge clk);
    check_state();
    bus.clr = c; bus.fwd_en = fe; bus.fwd_A = fa; bus.bwd_en = be; bus.dY = dy;
    model_step(c, fe, fa, be, dy);
  endtask

  task automatic wr(input logic signed [DW-1:0] fa); step(0, 1, fa, 0, '0); endtask
  task automatic rd(input logic signed [DW-1:0] dy); step(0, 0, '0, 1, dy); endtask
  task automatic idle();                            step(0, 0, '0, 0, '0); endtask

  // Monitor: every presented gradient must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.bwd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got dA=%0d expected no output", bus.dA);
      end else begin
        chk("sb_dA", bus.dA, sb.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.clr = 0; bus.fwd_en = 0; bus.fwd_A = '0; bus.bwd_en = 0; bus.dY = '0;
    model_reset();
    @(negedge clk);
    check_state();
    rst = 1'b0;

    // Directed mask pattern: 5, -3, 0, -128 then four dY=10.
    wr(8'sd5); wr(-8'sd3); wr(8'sd0); wr(-8'sd128);
    repeat (4) rd(8'sd10);
    idle(); idle();

    // Overflow on the 17th write, then drain all 16.
    for (int i = 0; i < 17; i++) wr(DW'($urandom));
    for (int i = 0; i < 16; i++) rd(DW'($urandom));
    idle();

    // Underflow with a concurrent write.
    step(1, 0, '0, 0, '0);
    step(0, 1, 8'sd1, 1, 8'sd7);
    idle();

    // Full buffer with simultaneous write and read for 20 cycles.
    step(1, 0, '0, 0, '0);
    for (int i = 0; i < 16; i++) wr(DW'($urandom));
    for (int i = 0; i < 20; i++) step(0, 1, -8'sd1, 1, -8'sd4);
    idle();

    // Asynchronous reset between edges with count=5.
    step(1, 0, '0, 0, '0);
    for (int i = 0; i < 5; i++) wr(DW'($urandom));
    @(negedge clk);
    check_state();
    bus.fwd_en = 0; bus.bwd_en = 0; bus.clr = 0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_dA", bus.dA, 0);
    chk("rst_valid", 32'(bus.bwd_valid), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    rd(8'sd9);
    idle();

    // clr with count=3 and ovf=1, strobes asserted in the clr cycle.
    for (int i = 0; i < 17; i++) wr(DW'($urandom));
    for (int i = 0; i < 13; i++) rd(DW'($urandom));
    step(1, 1, 8'sd3, 1, 8'sd3);
    idle();

    // Randomized traffic in phases of varying write/read bias.
    for (int p = 0; p < 8; p++) begin
      int wp = $urandom_range(20, 80);
      for (int i = 0; i < 50; i++) begin
        step($urandom_range(0, 39) == 0,
             $urandom_range(0, 99) < wp, DW'($urandom),
             $urandom_range(0, 99) >= wp, DW'($urandom));
      end
    end
    idle(); idle();
    @(negedge clk);
    check_state();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
